// File: rtl/tpu_line_memory_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : tpu_line_memory_pkg                                            |
// | Purpose : Shared constants, load-FSM state encoding and the address      |
// |           window helper for the TPU line memory.                         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package tpu_line_memory_pkg;

  localparam int LINE_BYTES = 128;
  localparam int LINE_W     = 1024;
  localparam int ADDR_W     = 12;
  localparam int LINES_W    = 9;
  localparam int BYTE_CNT_W = $clog2(LINE_BYTES);

  localparam logic [ADDR_W-1:0] WIN_BASE = 12'h400;
  localparam int                DEPTH    = 768;

  typedef enum logic [1:0] {
    LD_IDLE   = 2'd0,
    LD_FILL   = 2'd1,
    LD_COMMIT = 2'd2
  } ld_state_t;

  // True when line address a falls inside [base, base+depth).
  function automatic logic in_window(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] base,
                                     input int                depth);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(base);
    return (ia >= ib) && (ia < ib + depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_line_memory_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tpu_line_ram                                                   |
// | Purpose : Single-clock line array, one write port and one registered     |
// |           read port (read-before-write), block-RAM inferable.            |
// | Ports   : clk            clock                                           |
// |           we/waddr/wdata write port                                      |
// |           re/raddr       read enable / address                           |
// |           rdata          registered read data                            |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tpu_line_ram
  import tpu_line_memory_pkg::*;
#(
  parameter int WORDS = 768,
  parameter int IDX_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [WORDS];

  // Both accesses in one block: a same-address read returns the old line.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/tpu_line_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tpu_line_memory                                                |
// | Purpose : 1024-bit line memory for a TPU layer pipeline: 1-cycle line    |
// |           reads, full-line host write-back and a byte-stream line loader.|
// | Ports   : clk, iRst (sync, active-high), ena (global enable)             |
// |           addr -> data_out             line read, 1-cycle latency        |
// |           wr_en/wr_addr/wr_data        host line write (has priority)    |
// |           ld_start/ld_addr/ld_lines    start a streamed load             |
// |           ld_valid/ld_byte/ld_ready    byte stream handshake             |
// |           ld_busy/ld_done              load status                       |
// |           addr_error                   sticky out-of-window flag         |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tpu_line_memory
  import tpu_line_memory_pkg::ADDR_W, tpu_line_memory_pkg::LINE_W;
#(
  parameter logic [ADDR_W-1:0] WIN_BASE = tpu_line_memory_pkg::WIN_BASE,
  parameter int                DEPTH    = tpu_line_memory_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              iRst,
  input  logic              ena,
  input  logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] data_out,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [8:0]        ld_lines,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              addr_error
);

  import tpu_line_memory_pkg::LINES_W;
  import tpu_line_memory_pkg::LINE_BYTES;
  import tpu_line_memory_pkg::BYTE_CNT_W;
  import tpu_line_memory_pkg::ld_state_t;
  import tpu_line_memory_pkg::LD_IDLE;
  import tpu_line_memory_pkg::LD_FILL;
  import tpu_line_memory_pkg::LD_COMMIT;
  import tpu_line_memory_pkg::in_window;

  localparam int IDX_W = $clog2(DEPTH);

  ld_state_t              state;
  logic [ADDR_W-1:0]      ptr;
  logic [LINES_W-1:0]     line_cnt;
  logic [LINES_W-1:0]     lines_q;
  logic [BYTE_CNT_W-1:0]  byte_cnt;
  logic [LINE_W-1:0]      line_buf;
  logic                   rd_valid;
  logic [LINE_W-1:0]      ram_q;

  logic rd_in;
  logic host_in;
  logic host_ok;
  logic host_bad;
  logic ptr_in;
  logic commit_go;
  logic commit_wr;

  assign rd_in     = in_window(addr, WIN_BASE, DEPTH);
  assign host_in   = in_window(wr_addr, WIN_BASE, DEPTH);
  assign ptr_in    = in_window(ptr, WIN_BASE, DEPTH);
  assign host_ok   = ena & wr_en & host_in;
  assign host_bad  = ena & wr_en & ~host_in;
  // An in-window host write wins the single write port; commit waits.
  assign commit_go = ena & (state == LD_COMMIT) & ~host_ok;
  assign commit_wr = commit_go & ptr_in;

  tpu_line_ram #(
    .WORDS (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (host_ok | commit_wr),
    .waddr (host_ok ? IDX_W'(wr_addr - WIN_BASE) : IDX_W'(ptr - WIN_BASE)),
    .wdata (host_ok ? wr_data : line_buf),
    .re    (ena & rd_in),
    .raddr (IDX_W'(addr - WIN_BASE)),
    .rdata (ram_q)
  );

  // The RAM output register is not reset; rd_valid masks it to zero after
  // reset and for out-of-window reads, and holds with ena like the RAM does.
  assign data_out = rd_valid ? ram_q : '0;
  assign ld_ready = ena & (state == LD_FILL);
  assign ld_busy  = (state != LD_IDLE);

  always_ff @(posedge clk) begin
    if (iRst) begin
      state      <= LD_IDLE;
      ptr        <= '0;
      line_cnt   <= '0;
      lines_q    <= '0;
      byte_cnt   <= '0;
      rd_valid   <= 1'b0;
      ld_done    <= 1'b0;
      addr_error <= 1'b0;
    end else if (ena) begin
      rd_valid <= rd_in;
      ld_done  <= 1'b0;
      if (!rd_in || host_bad || (commit_go && !ptr_in)) begin
        addr_error <= 1'b1;
      end
      case (state)
        LD_IDLE: begin
          if (ld_start) begin
            if (ld_lines == '0) begin
              ld_done <= 1'b1;
            end else begin
              state    <= LD_FILL;
              ptr      <= ld_addr;
              line_cnt <= '0;
              byte_cnt <= '0;
              lines_q  <= ld_lines;
            end
          end
        end
        LD_FILL: begin
          if (ld_valid) begin
            line_buf[{byte_cnt, 3'b000} +: 8] <= ld_byte;
            byte_cnt <= byte_cnt + 1'b1;
            if (byte_cnt == BYTE_CNT_W'(LINE_BYTES - 1)) begin
              state <= LD_COMMIT;
            end
          end
        end
        LD_COMMIT: begin
          if (!host_ok) begin
            ptr <= ptr + 1'b1;
            if (line_cnt == lines_q - 1'b1) begin
              state   <= LD_IDLE;
              ld_done <= 1'b1;
            end else begin
              state    <= LD_FILL;
              line_cnt <= line_cnt + 1'b1;
              byte_cnt <= '0;
            end
          end
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tpu_line_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_tpu_line_memory                                             |
// | Purpose : Self-checking bench for tpu_line_memory: vector table, corner  |
// |           sequences and randomized traffic against a line-level model.   |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_tpu_line_memory;

  logic          clk = 1'b0;
  logic          iRst, ena;
  logic [11:0]   addr, wr_addr, ld_addr;
  logic [1023:0] data_out, wr_data;
  logic          wr_en, ld_start, ld_valid;
  logic [8:0]    ld_lines;
  logic [7:0]    ld_byte;
  logic          ld_ready, ld_busy, ld_done, addr_error;

  always #5 clk = ~clk;

  tpu_line_memory dut (
    .clk(clk), .iRst(iRst), .ena(ena), .addr(addr), .data_out(data_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_lines(ld_lines),
    .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done), .addr_error(addr_error)
  );

  int checks = 0;
  int errors = 0;
  logic [1023:0] mdl [int];   // known line contents, keyed by line address
  bit err_exp = 1'b0;
  int done_seen = 0;

  typedef struct {
    bit          is_wr;
    logic [11:0] a;
    logic [7:0]  seed;
    bit          zero;
    bit          err;
  } vec_t;
  vec_t tbl [12];

  // Line whose byte k is seed+k (mod 256).
  function automatic logic [1023:0] mk(input int seed);
    logic [1023:0] v;
    for (int k = 0; k < 128; k++) v[k*8 +: 8] = 8'(seed + k);
    return v;
  endfunction

  function automatic bit inwin(input logic [11:0] a);
    return (a >= 12'h400) && (a <= 12'h6FF);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    int b;
    checks++;
    if (act !== exp) begin
      b = 0;
      for (int k = 127; k >= 0; k--) if (act[k*8 +: 8] !== exp[k*8 +: 8]) b = k;
      errors++;
      $display("FAIL %s byte %0d actual=%h required=%h (low bytes actual=%h required=%h)",
               nm, b, act[b*8 +: 8], exp[b*8 +: 8], act[127:0], exp[127:0]);
    end
  endtask

  task automatic do_reset();
    iRst = 1'b1;
    tick();
    tick();
    iRst = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic hw(input logic [11:0] a, input logic [1023:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    if (inwin(a)) mdl[int'(a)] = d;
    else err_exp = 1'b1;
  endtask

  task automatic rd(input logic [11:0] a, input string nm);
    addr = a;
    tick();
    if (!inwin(a)) begin
      err_exp = 1'b1;
      chkw(nm, data_out, '0);
    end else if (mdl.exists(int'(a))) begin
      chkw(nm, data_out, mdl[int'(a)]);
    end
    chk($sformatf("%s_err", nm), {31'd0, addr_error}, {31'd0, err_exp});
    addr = 12'h400;
  endtask

  // Stream nbytes bytes (seed+k); in random mode valid and ena toggle.
  task automatic feed(input int seed, input int nbytes, input bit rnd);
    int k = 0;
    int guard = 0;
    bit acc;
    while (k < nbytes && guard < 5000) begin
      ena      = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      ld_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      ld_byte  = 8'(seed + k);
      #1;
      if (!ena) chk("ready_when_disabled", {31'd0, ld_ready}, 32'd0);
      acc = ld_valid && ld_ready;
      tick();
      if (ld_done) done_seen++;
      if (acc) k++;
      guard++;
    end
    ena = 1'b1;
    ld_valid = 1'b0;
    chk("feed_bytes_accepted", k, nbytes);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (ld_busy && guard < 20) begin
      tick();
      if (ld_done) done_seen++;
      guard++;
    end
    chk("idle_reached", {31'd0, ld_busy}, 32'd0);
  endtask

  task automatic load(input logic [11:0] a, input int n, input int seed, input bit rnd);
    logic [11:0] la;
    ld_start = 1'b1; ld_addr = a; ld_lines = 9'(n);
    tick();
    ld_start = 1'b0;
    done_seen = 0;
    feed(seed, 128 * n, rnd);
    wait_idle();
    chk("load_done_pulses", done_seen, 1);
    for (int i = 0; i < n; i++) begin
      la = a + 12'(i);
      if (inwin(la)) mdl[int'(la)] = mk(seed + 128 * i);
      else err_exp = 1'b1;
    end
  endtask

  initial begin
    logic [1023:0] old;
    logic [11:0]   ra;
    int            op;

    tbl[0]  = '{1'b1, 12'h600, 8'h11, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 12'h600, 8'h11, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 12'h400, 8'h22, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 12'h6FF, 8'h33, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 12'h500, 8'h44, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 12'h6A0, 8'h55, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 12'h6FF, 8'h33, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 12'h400, 8'h22, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 12'h700, 8'h77, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 12'h6FF, 8'h33, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 12'h400, 8'h22, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 12'h3FF, 8'h00, 1'b1, 1'b1};

    iRst = 1'b1; ena = 1'b1; addr = 12'h400;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    ld_start = 1'b0; ld_addr = '0; ld_lines = '0; ld_valid = 1'b0; ld_byte = '0;
    tick();
    tick();
    chkw("reset_data_out", data_out, '0);
    chk("reset_status", {28'd0, ld_ready, ld_busy, ld_done, addr_error}, 32'd0);
    iRst = 1'b0;

    // Vector table: host writes and reads including window boundaries.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].is_wr) begin
        hw(tbl[i].a, mk(int'(tbl[i].seed)));
      end else begin
        addr = tbl[i].a;
        tick();
        chkw($sformatf("vec%0d_data", i), data_out, tbl[i].zero ? '0 : mk(int'(tbl[i].seed)));
        addr = 12'h400;
      end
      chk($sformatf("vec%0d_err", i), {31'd0, addr_error}, {31'd0, tbl[i].err});
    end
    do_reset();

    // Read and write of the same line in one cycle returns the old line.
    old = mdl[12'h600];
    wr_en = 1'b1; wr_addr = 12'h600; wr_data = mk(8'h5A); addr = 12'h600;
    tick();
    wr_en = 1'b0;
    chkw("read_during_write_old", data_out, old);
    mdl[12'h600] = mk(8'h5A);
    rd(12'h600, "read_after_write_new");

    // ena low holds data_out and drops writes.
    ena = 1'b0; wr_en = 1'b1; wr_addr = 12'h600; wr_data = mk(8'hEE); addr = 12'h6FF;
    tick();
    ena = 1'b1; wr_en = 1'b0; addr = 12'h400;
    chkw("ena_low_hold", data_out, mdl[12'h600]);
    rd(12'h600, "ena_low_write_dropped");

    // Two-line load, continuous stream.
    load(12'h680, 2, 0, 1'b0);
    rd(12'h680, "load_line0");
    rd(12'h681, "load_line1");

    // Host write in the COMMIT cycle delays the commit by one cycle.
    ld_start = 1'b1; ld_addr = 12'h401; ld_lines = 9'd1;
    tick();
    ld_start = 1'b0;
    feed(8'h90, 128, 1'b0);
    chk("commit_state_busy", {31'd0, ld_busy}, 32'd1);
    wr_en = 1'b1; wr_addr = 12'h400; wr_data = mk(8'hA0);
    tick();
    wr_en = 1'b0;
    chk("commit_deferred_busy", {31'd0, ld_busy}, 32'd1);
    chk("commit_deferred_done", {31'd0, ld_done}, 32'd0);
    tick();
    chk("commit_late_done", {31'd0, ld_done}, 32'd1);
    chk("commit_late_idle", {31'd0, ld_busy}, 32'd0);
    mdl[12'h400] = mk(8'hA0);
    mdl[12'h401] = mk(8'h90);
    rd(12'h400, "collide_host_line");
    rd(12'h401, "collide_load_line");

    // Zero-line load: done on the next cycle, nothing written.
    ld_start = 1'b1; ld_addr = 12'h6A0; ld_lines = 9'd0;
    tick();
    ld_start = 1'b0;
    chk("zero_lines_done", {30'd0, ld_done, ld_busy}, 32'd2);
    tick();
    chk("zero_lines_done_single", {31'd0, ld_done}, 32'd0);
    rd(12'h6A0, "zero_lines_no_write");

    // ld_start while busy is ignored.
    ld_start = 1'b1; ld_addr = 12'h6F0; ld_lines = 9'd1;
    tick();
    ld_start = 1'b0;
    feed(8'h30, 10, 1'b0);
    ld_start = 1'b1; ld_addr = 12'h6A0; ld_lines = 9'd1;
    tick();
    ld_start = 1'b0;
    done_seen = 0;
    feed(8'h3A, 118, 1'b0);
    wait_idle();
    chk("busy_start_single_done", done_seen, 1);
    mdl[12'h6F0] = mk(8'h30);
    rd(12'h6F0, "busy_start_orig_line");
    rd(12'h6A0, "busy_start_ignored_line");

    // Reset mid-load discards the partial line.
    ld_start = 1'b1; ld_addr = 12'h500; ld_lines = 9'd1;
    tick();
    ld_start = 1'b0;
    feed(8'hC0, 60, 1'b0);
    iRst = 1'b1;
    tick();
    chkw("midload_reset_data", data_out, '0);
    chk("midload_reset_status", {28'd0, ld_ready, ld_busy, ld_done, addr_error}, 32'd0);
    iRst = 1'b0;
    err_exp = 1'b0;
    rd(12'h500, "midload_line_kept");
    load(12'h500, 1, 8'hD0, 1'b0);
    rd(12'h500, "reload_after_reset");

    // Randomized traffic against the line-level model.
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 9));
      ra = ($urandom_range(0, 9) == 0) ? 12'hFFE : 12'($urandom_range(12'h3F8, 12'h708));
      if (op <= 2) hw(ra, {32{$urandom()}});
      else if (op <= 6) rd(ra, "rand_read");
      else load(ra, int'($urandom_range(1, 3)), int'($urandom_range(0, 255)), 1'b1);
    end
    foreach (mdl[k]) rd(12'(k), "rand_final_sweep");

    // Out-of-window read: zero data and sticky error until reset.
    rd(12'h7FF, "oow_read");
    tick();
    tick();
    chk("oow_error_sticky", {31'd0, addr_error}, 32'd1);
    do_reset();
    chk("oow_error_cleared", {31'd0, addr_error}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tpu_line_memory.md
TPU_LINE_MEMORY -- requirements
Module: tpu_line_memory

Interface
REQ-001 Parameter WIN_BASE, default 12'h400: first line address held by the memory.
REQ-002 Parameter DEPTH, default 768: number of 1024-bit lines held, covering 12'h400..12'h6FF (weights, activations, biases).
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 iRst  in  1  reset, synchronous, active-high.
REQ-005 ena  in  1  block enable; low freezes all state.
REQ-006 addr  in  12  read line address from the layer controller.
REQ-007 data_out  out  1024  registered read data; byte k at bits [8k+7:8k].
REQ-008 wr_en / wr_addr / wr_data  in  1 / 12 / 1024  full-line write-back of a layer result.
REQ-009 ld_start / ld_addr / ld_lines  in  1 / 12 / 9  start a byte-stream load of ld_lines lines at ld_addr.
REQ-010 ld_valid / ld_byte  in  1 / 8  load byte stream.
REQ-011 ld_ready  out  1  byte accepted when ld_valid and ld_ready are both high.
REQ-012 ld_busy  out  1  load in progress.
REQ-013 ld_done  out  1  one-cycle pulse when a load completes.
REQ-014 addr_error  out  1  sticky flag for any out-of-window access.

Function
REQ-015 Read latency SHALL be exactly 1 cycle: data_out after edge N reflects addr sampled at edge N.
REQ-016 Read of a line being written in the same cycle SHALL return the old contents.
REQ-017 Out-of-window read (addr < WIN_BASE or >= WIN_BASE+DEPTH) SHALL return all zeros and set addr_error.
REQ-018 A host write SHALL occur when wr_en is high with an in-window wr_addr; an out-of-window write SHALL be dropped and set addr_error.
REQ-019 Load FSM states: IDLE, FILL, COMMIT.
REQ-020 IDLE -> FILL on ld_start with ld_lines != 0; this latches line pointer = ld_addr, line count = 0, byte count = 0.
REQ-021 ld_start with ld_lines == 0 SHALL write nothing, stay in IDLE and pulse ld_done on the next cycle.
REQ-022 ld_start while ld_busy SHALL be ignored.
REQ-023 FILL: ld_ready = 1.
- Each accepted byte goes to assembly-buffer byte [byte count]; byte count increments.
- Acceptance of byte 127 -> COMMIT.
REQ-024 COMMIT: ld_ready = 0; the buffer is written to the line pointer.
REQ-025 A simultaneous in-window host write (wr_en) SHALL have priority; the commit SHALL wait in COMMIT until a cycle without one.
REQ-026 After a commit:
- line pointer increments, wrapping 12'hFFF -> 12'h000;
- if line count = ld_lines-1 -> IDLE and pulse ld_done in the same cycle;
- otherwise -> FILL with byte count = 0.
REQ-027 A commit to an out-of-window line pointer SHALL be dropped and set addr_error; the load continues.
REQ-028 ld_busy SHALL be high in FILL and COMMIT.
REQ-029 ena low SHALL hold data_out, FSM state, counters and the buffer; writes are ignored and ld_ready = 0.

Reset
REQ-030 iRst SHALL take priority over ena.
REQ-031 iRst SHALL clear data_out, ld_ready, ld_busy, ld_done and addr_error to 0 and force IDLE.
REQ-032 Reset mid-load SHALL discard the partial line; memory array contents are not reset.

Structure
REQ-033 Shared package: LINE_BYTES=128, LINE_W=1024, ADDR_W=12, WIN_BASE, DEPTH and the state encoding.
REQ-034 One sub-module, tpu_line_ram: single-clock array, one write port and one registered read port, inferable as block RAM.

Verification
REQ-035 Host write 12'h600 = pattern P, then read 12'h600 -> data_out = P one cycle after the addr cycle.
REQ-036 Load ld_addr=12'h680, ld_lines=2, bytes 0..255 streamed continuously.
- ld_done pulses once after the second commit.
- Read 12'h680 gives byte k = k; read 12'h681 gives byte k = 128+k.
REQ-037 Assert wr_en to 12'h400 in the COMMIT cycle of a 1-line load to 12'h401.
- Commit delayed exactly one cycle; both lines correct.
REQ-038 Read 12'h7FF -> data_out = 0 and addr_error = 1, remaining 1 until iRst.
REQ-039 Assert iRst after 60 bytes of a load to 12'h500.
- Outputs return to 0; line 12'h500 keeps its prior contents.
- A new ld_start is accepted.
REQ-040 ld_start with ld_lines=0 -> ld_done pulses on the next cycle, no write; ld_start while busy -> ignored.
